// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the level-reporting synchronous FIFO.
package sync_fifo_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 32;

   // Pointer width: address bits plus one wrap bit that tells full from empty.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Simple dual-port storage: one write port and one synchronous read port.
// Contents are never reset; the read register holds when re_i is low.
module fifo_ram_2p #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Write on we_i; read returns the pre-write contents of the addressed word.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_level.sv
// Synchronous FIFO with fill level, threshold flags and sticky error flags.
//
// Handshake: a write is taken on a rising edge where we=1 and writable=1;
// a read is taken where re=1 and readable=1. Requests made while the matching
// ready signal is low do not touch storage, but they set the sticky
// overflow/underflow flag. flush overrides both requests for that edge.
module sync_fifo_level
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int FWFT      = 1,
   parameter int AFULL_TH  = DEPTH - 4,
   parameter int AEMPTY_TH = 4
) (
   input  logic                        sys_clk,
   input  logic                        sys_rst_n,
   input  logic                        we,
   input  logic [WIDTH-1:0]            din,
   output logic                        writable,
   input  logic                        re,
   output logic                        readable,
   output logic [WIDTH-1:0]            dout,
   input  logic                        flush,
   input  logic                        clear_err,
   output logic [ptr_width(DEPTH)-1:0] level,
   output logic                        almost_full,
   output logic                        almost_empty,
   output logic                        overflow,
   output logic                        underflow
);

   localparam int PW = ptr_width(DEPTH);
   localparam int AW = PW - 1;

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             full, empty;
   logic             wr_acc, rd_acc;
   logic             ram_re;
   logic [AW-1:0]    ram_raddr;
   logic [WIDTH-1:0] ram_rdata;
   logic [PW-1:0]    level_w;

   // Full: same address, opposite lap. Empty: identical pointers.
   assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign writable = ~full;
   assign readable = ~empty;
   assign wr_acc   = we & ~full & ~flush;
   assign rd_acc   = re & ~empty & ~flush;

   // Pointer advance, with flush returning both pointers to zero.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
         if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   // Sticky error flags; a new error in a clearing cycle wins over the clear.
   always_comb begin
      overflow_d  = (overflow_q & ~clear_err) | (we & full);
      underflow_d = (underflow_q & ~clear_err) | (re & empty);
   end

   // Pointer and error-flag registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Modulo-2*DEPTH difference of the pointers is the occupancy.
   assign level_w      = wr_ptr_q - rd_ptr_q;
   assign level        = level_w;
   assign almost_full  = (level_w >= PW'(AFULL_TH));
   assign almost_empty = (level_w <= PW'(AEMPTY_TH));
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   fifo_ram_2p #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk_i   (sys_clk),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (din),
      .re_i    (ram_re),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   if (FWFT != 0) begin : g_fwft
      // The RAM continuously prefetches the next head. When the word being
      // written this edge is that head, the RAM returns stale data, so a
      // one-entry bypass supplies din instead for the following cycle.
      logic             byp_sel_q;
      logic [WIDTH-1:0] byp_data_q;

      assign ram_re    = 1'b1;
      assign ram_raddr = rd_ptr_d[AW-1:0];

      // Capture the written word when it lands on the upcoming head slot.
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n) begin
            byp_sel_q  <= 1'b0;
            byp_data_q <= '0;
         end else begin
            byp_sel_q  <= wr_acc && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]);
            byp_data_q <= din;
         end
      end

      assign dout = empty ? '0 : (byp_sel_q ? byp_data_q : ram_rdata);
   end else begin : g_reg
      // Registered read: RAM output only moves on an accepted read. Until the
      // first read after reset the un-reset RAM register is masked to zero.
      logic dout_vld_q;

      assign ram_re    = rd_acc;
      assign ram_raddr = rd_ptr_q[AW-1:0];

      // Remember that the RAM read register holds a real word.
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n) dout_vld_q <= 1'b0;
         else if (rd_acc) dout_vld_q <= 1'b1;
      end

      assign dout = dout_vld_q ? ram_rdata : '0;
   end

endmodule

// File: doc/sync_fifo_level.md
SYNC_FIFO_LEVEL -- requirements
Module: sync_fifo_level

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of entries, power of two, minimum 4.
REQ-003 SHALL have parameter FWFT, default 1: 1 = first-word-fall-through, 0 = registered read.
REQ-004 SHALL have parameter AFULL_TH, default DEPTH-4; almost_full is asserted when level >= AFULL_TH.
REQ-005 SHALL have parameter AEMPTY_TH, default 4; almost_empty is asserted when level <= AEMPTY_TH.
REQ-006 SHALL have port sys_clk, input, 1, the single clock; all logic is on the rising edge.
REQ-007 SHALL have port sys_rst_n, input, 1, reset: asynchronous, active-low.
REQ-008 SHALL have port we, input, 1, write request.
REQ-009 SHALL have port din, input, WIDTH, write data.
REQ-010 SHALL have port writable, output, 1, high when not full.
REQ-011 SHALL have port re, input, 1, read request.
REQ-012 SHALL have port readable, output, 1, high when dout is valid / not empty.
REQ-013 SHALL have port dout, output, WIDTH, read data.
REQ-014 SHALL have port flush, input, 1, synchronous clear of contents.
REQ-015 SHALL have port clear_err, input, 1, clears the sticky error flags.
REQ-016 SHALL have port level, output, log2(DEPTH)+1, number of stored entries.
REQ-017 SHALL have ports almost_full and almost_empty, output, 1 each, threshold flags.
REQ-018 SHALL have ports overflow and underflow, output, 1 each, sticky error flags.

Function
REQ-019 SHALL accept a write only when we & writable, and a read only when re & readable; otherwise the request has no effect on storage.
REQ-020 SHALL keep write and read pointers log2(DEPTH)+1 bits wide, binary, wrapping modulo 2*DEPTH; the address is the low log2(DEPTH) bits.
REQ-021 SHALL define full as equal addresses with differing MSBs, and empty as equal pointers.
REQ-022 SHALL update level on the cycle after each accepted operation: +1 for a write only, -1 for a read only, unchanged when both are accepted.
REQ-023 SHALL allow a simultaneous accepted read and write when 0 < level < DEPTH.
REQ-024 SHALL ignore we while full (no write); a read accepted in the same cycle still happens.
REQ-025 SHALL ignore re while empty; a write in the same cycle still happens.
REQ-026 FWFT=1: dout SHALL present the head entry whenever readable=1, with readable rising 1 cycle after the first write into an empty FIFO.
REQ-027 FWFT=0: readable SHALL equal not-empty; dout SHALL update 1 cycle after an accepted read and hold otherwise.
REQ-028 SHALL set overflow on any cycle with we=1 and writable=0, and set underflow on any cycle with re=1 and readable=0; both hold until clear_err or reset.
REQ-029 If clear_err and a new error occur in the same cycle, the flag SHALL remain set.
REQ-030 flush SHALL zero both pointers and level on the next edge, overriding we/re in the same cycle; it SHALL NOT alter overflow or underflow.

Reset
REQ-031 While sys_rst_n=0, the block SHALL asynchronously hold: pointers 0, level 0, writable 1, readable 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, dout 0.
REQ-032 Storage contents SHALL NOT be reset; a reset in mid-operation discards all entries.

Structure
REQ-033 Package sync_fifo_pkg SHALL hold the default WIDTH/DEPTH constants and a clog2-based pointer-width function.
REQ-034 Storage SHALL be the sub-module fifo_ram_2p: one write port and one synchronous read port, no reset.

Verification
REQ-035 Fill test: DEPTH=32, write 32 words 0..31 with no reads -> writable=0 after the 32nd write, level=32, almost_full set since level 28.
REQ-036 Overflow test: one more write while full -> overflow=1, level stays 32; read all -> data 0..31 in order, then readable=0.
REQ-037 Concurrent/wrap test: with level=16, we=re=1 for 100 cycles -> level stays 16, data in order across the pointer wrap.
REQ-038 Underflow test: re while empty -> underflow=1; clear_err -> underflow=0 on the next cycle.
REQ-039 Latency test: FWFT=1, single write of 0xA5 into empty -> readable and dout=0xA5 one cycle later; FWFT=0 -> dout=0xA5 one cycle after re.
REQ-040 Flush/reset test: flush with we=1 at level 10 -> level=0, readable=0 next cycle; assert sys_rst_n=0 mid-burst -> all outputs at reset values immediately.
